// File: rtl/dev_intercon_pkg.sv
// Shared definitions for the device interconnect: FSM states, control
// register word indices, STATUS field layout and small helper functions.
package dev_intercon_pkg;

  // Transaction FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  // Control register word index (byte offsets 0x0, 0x4, 0x8, 0xC)
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_WIN    = 2'd1;
  localparam logic [1:0] REG_EN     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  // STATUS field positions
  localparam int STAT_CNT_LSB  = 0;
  localparam int STAT_CNT_W    = 16;
  localparam int STAT_LAST_LSB = 16;
  localparam int STAT_LAST_W   = 4;

  // Width of the target index; value NS selects SRAM
  localparam int SEL_W = 5;

  // Assemble the STATUS read value from its fields
  function automatic logic [31:0] pack_status(input logic [15:0] cnt,
                                              input logic [3:0]  last);
    logic [31:0] s;
    s = 32'd0;
    s[STAT_CNT_LSB +: STAT_CNT_W]   = cnt;
    s[STAT_LAST_LSB +: STAT_LAST_W] = last;
    return s;
  endfunction

  // Saturating 16-bit increment for the timeout counter
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? 16'hFFFF : v + 16'd1;
  endfunction

endpackage

// File: rtl/dev_intercon_decode.sv
// Combinational address decode: control block hit, device window hit,
// lowest-index slot match and refusal (no slot or disabled slot).
module dev_intercon_decode
  import dev_intercon_pkg::*;
#(
  parameter int                     NS       = 4,
  parameter int                     MASK_LEN = 10,
  parameter logic [NS*MASK_LEN-1:0] BASE     = {10'h0C0, 10'h080, 10'h040, 10'h000},
  parameter logic [NS*MASK_LEN-1:0] MASK     = {10'h3C0, 10'h3C0, 10'h3C0, 10'h3C0}
) (
  input  logic [31:0]      addr,
  input  logic [31:0]      ctrl_base,
  input  logic [31:0]      win_base,
  input  logic [NS-1:0]    en,
  output logic             hit_ctrl,
  output logic [1:0]       ctrl_idx,
  output logic             hit_win,
  output logic [SEL_W-1:0] sel_idx,
  output logic             refused
);

  logic [31:0] diff;
  logic        found;
  logic        match_en;

  // Control block hit is an exact word match on one of four words above ctrl_base
  always_comb begin
    diff     = addr - ctrl_base;
    hit_ctrl = (diff[31:4] == 28'd0) && (diff[1:0] == 2'd0);
    ctrl_idx = diff[3:2];
    hit_win  = !hit_ctrl && (addr[31:MASK_LEN] == win_base[31:MASK_LEN]);
  end

  // Priority-encode slot matches (lowest index wins) and gate with enables
  always_comb begin
    found    = 1'b0;
    match_en = 1'b0;
    sel_idx  = SEL_W'(NS);
    refused  = 1'b0;
    for (int i = 0; i < NS; i++) begin
      if (!found &&
          ((addr[MASK_LEN-1:0] & MASK[i*MASK_LEN +: MASK_LEN]) == BASE[i*MASK_LEN +: MASK_LEN])) begin
        found    = 1'b1;
        sel_idx  = SEL_W'(i);
        match_en = en[i];
      end else begin
        found    = found;
      end
    end
    if (!hit_win) begin
      sel_idx = SEL_W'(NS);
      refused = 1'b0;
    end else begin
      refused = !found || !match_en;
    end
  end

endmodule

// File: rtl/dev_intercon_ext.sv
// Device interconnect: latches one controller request at a time, routes it
// to a device slot, SRAM or the local control block, watches for a bus
// timeout and returns a registered response.
module dev_intercon_ext
  import dev_intercon_pkg::*;
#(
  parameter int                     NS       = 4,
  parameter int                     MASK_LEN = 10,
  parameter logic [NS*MASK_LEN-1:0] BASE     = {10'h0C0, 10'h080, 10'h040, 10'h000},
  parameter logic [NS*MASK_LEN-1:0] MASK     = {10'h3C0, 10'h3C0, 10'h3C0, 10'h3C0},
  parameter logic [31:0]            CTRL_RST = 32'h0000_FF00,
  parameter logic [31:0]            WIN_RST  = 32'h0000_FC00,
  parameter int                     TMO      = 64,
  parameter logic [31:0]            ERR_DATA = 32'hDEAD_BEEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_stb,
  input  logic [31:0]      i_addr,
  input  logic [31:0]      i_dtw,
  input  logic             i_rw,
  output logic             o_ack,
  output logic             o_err,
  output logic             o_busy,
  output logic [31:0]      o_dtr,
  input  logic [32*NS-1:0] i_dtr,
  input  logic [NS-1:0]    i_ack,
  output logic [NS-1:0]    o_stb,
  output logic [31:0]      o_addr,
  output logic [31:0]      o_dtw,
  output logic             o_rw,
  output logic             sstb,
  input  logic             sack,
  input  logic [31:0]      sdtr
);

  localparam int TW = $clog2(TMO + 1);

  logic [1:0]       state;
  logic [SEL_W-1:0] sel_r;
  logic [TW-1:0]    tmo_cnt;
  logic [15:0]      err_cnt;
  logic [3:0]       last;
  logic [31:0]      ctrl_base;
  logic [31:0]      win_base;
  logic [NS-1:0]    en;

  logic             dec_ctrl;
  logic [1:0]       dec_cidx;
  logic             dec_win;
  logic [SEL_W-1:0] dec_sel;
  logic             dec_refused;

  logic [NS-1:0]    stb_vec;
  logic             ack_sel;
  logic [31:0]      dtr_sel;
  logic [31:0]      ctrl_rdata;

  dev_intercon_decode #(
    .NS       (NS),
    .MASK_LEN (MASK_LEN),
    .BASE     (BASE),
    .MASK     (MASK)
  ) u_decode (
    .addr      (i_addr),
    .ctrl_base (ctrl_base),
    .win_base  (win_base),
    .en        (en),
    .hit_ctrl  (dec_ctrl),
    .ctrl_idx  (dec_cidx),
    .hit_win   (dec_win),
    .sel_idx   (dec_sel),
    .refused   (dec_refused)
  );

  // One-hot strobe vector for the slot chosen by the decoder
  always_comb begin
    stb_vec = '0;
    for (int i = 0; i < NS; i++) begin
      if (dec_sel == SEL_W'(i)) begin
        stb_vec[i] = 1'b1;
      end else begin
        stb_vec[i] = 1'b0;
      end
    end
  end

  // Ack and read data from the latched target only; others are ignored
  always_comb begin
    ack_sel = sack;
    dtr_sel = sdtr;
    for (int i = 0; i < NS; i++) begin
      if (sel_r == SEL_W'(i)) begin
        ack_sel = i_ack[i];
        dtr_sel = i_dtr[32*i +: 32];
      end else begin
        ack_sel = ack_sel;
      end
    end
  end

  // Control block read mux
  always_comb begin
    ctrl_rdata = 32'd0;
    case (dec_cidx)
      REG_CTRL:   ctrl_rdata = ctrl_base;
      REG_WIN:    ctrl_rdata = win_base;
      REG_EN:     ctrl_rdata = {{(32-NS){1'b0}}, en};
      REG_STATUS: ctrl_rdata = pack_status(err_cnt, last);
      default:    ctrl_rdata = 32'd0;
    endcase
  end

  // Transaction FSM, latched request, control registers and response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      o_ack     <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
      o_stb     <= '0;
      sstb      <= 1'b0;
      o_rw      <= 1'b0;
      o_dtr     <= 32'd0;
      o_addr    <= 32'd0;
      o_dtw     <= 32'd0;
      sel_r     <= '0;
      tmo_cnt   <= '0;
      err_cnt   <= 16'd0;
      last      <= 4'd0;
      ctrl_base <= CTRL_RST;
      win_base  <= WIN_RST;
      en        <= '1;
    end else begin
      o_ack <= 1'b0;
      o_stb <= '0;
      sstb  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_stb) begin
            o_addr <= i_addr;
            o_dtw  <= i_dtw;
            o_rw   <= i_rw;
            sel_r  <= dec_sel;
            o_busy <= 1'b1;
            if (dec_ctrl) begin
              state <= ST_RESP;
              o_ack <= 1'b1;
              o_err <= 1'b0;
              o_dtr <= i_rw ? 32'd0 : ctrl_rdata;
              if (i_rw) begin
                case (dec_cidx)
                  REG_CTRL:   ctrl_base <= {i_dtw[31:2], 2'b00};
                  REG_WIN:    win_base  <= {i_dtw[31:MASK_LEN], {MASK_LEN{1'b0}}};
                  REG_EN:     en        <= i_dtw[NS-1:0];
                  REG_STATUS: err_cnt   <= 16'd0;
                  default:    err_cnt   <= err_cnt;
                endcase
              end
            end else if (dec_refused) begin
              state <= ST_RESP;
              o_ack <= 1'b1;
              o_err <= 1'b1;
              o_dtr <= ERR_DATA;
            end else begin
              state   <= ST_REQ;
              tmo_cnt <= TW'(1);
              if (dec_win) begin
                o_stb <= stb_vec;
              end else begin
                sstb  <= 1'b1;
              end
            end
          end
        end
        ST_REQ: begin
          if (ack_sel) begin
            state <= ST_RESP;
            o_ack <= 1'b1;
            o_err <= 1'b0;
            o_dtr <= dtr_sel;
          end else begin
            state   <= ST_WAIT;
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_WAIT: begin
          if (ack_sel) begin
            state <= ST_RESP;
            o_ack <= 1'b1;
            o_err <= 1'b0;
            o_dtr <= dtr_sel;
          end else if (tmo_cnt == TW'(TMO)) begin
            state   <= ST_RESP;
            o_ack   <= 1'b1;
            o_err   <= 1'b1;
            o_dtr   <= ERR_DATA;
            err_cnt <= sat_inc16(err_cnt);
            last    <= sel_r[3:0];
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_err  <= 1'b0;
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
          o_err  <= 1'b0;
        end
      endcase
    end
  end

endmodule
